// File: rtl/audio_pkg.sv
// Shared audio constants, frame type and the dither LFSR step used by the PDM DAC.
// The LFSR is only instantiated when AUDIO_PDM_DITHER_EN is defined.
package audio_pkg;

    localparam int AUDIO_SAMPLE_WIDTH      = 16;
    localparam int AUDIO_CLOCKS_PER_SAMPLE = 256;

    localparam logic [15:0] AUDIO_LFSR_TAPS = 16'hB400;
    localparam logic [15:0] AUDIO_LFSR_SEED = 16'hACE1;

    typedef struct packed {
        logic signed [AUDIO_SAMPLE_WIDTH-1:0] left;
        logic signed [AUDIO_SAMPLE_WIDTH-1:0] right;
    } audio_frame_t;

    function automatic logic [15:0] lfsrNext(input logic [15:0] state);
        return state[0] ? ((state >> 1) ^ AUDIO_LFSR_TAPS) : (state >> 1);
    endfunction

endpackage

// File: rtl/pdm_modulator_ch.sv
// One channel of the first-order delta-sigma modulator: offset-binary accumulator,
// registered carry and registered output bit (two cycles from sample to pin).
module pdm_modulator_ch
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = AUDIO_SAMPLE_WIDTH
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [1:0]              dither,
    output logic                    dac
);

    logic [SAMPLE_WIDTH-1:0] acc;
    logic [SAMPLE_WIDTH-1:0] offsetSample;
    logic [SAMPLE_WIDTH:0]   sum;
    logic                    carry;

    always_comb begin
        offsetSample = {~sample[SAMPLE_WIDTH-1], sample[SAMPLE_WIDTH-2:0]};
        sum = {1'b0, acc} + {1'b0, offsetSample} + {{(SAMPLE_WIDTH-1){1'b0}}, dither};
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            acc   <= '0;
            carry <= 1'b0;
            dac   <= 1'b0;
        end else begin
            acc   <= sum[SAMPLE_WIDTH-1:0];
            carry <= sum[SAMPLE_WIDTH];
            dac   <= carry;
        end
    end

endmodule

// File: rtl/audio_pdm_dac.sv
// Stereo PDM audio DAC: 2-frame input buffer, sample-period tick, per-channel modulators.
// Define AUDIO_PDM_DITHER_EN to add LFSR dither into both accumulators.
module audio_pdm_dac
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH      = AUDIO_SAMPLE_WIDTH,
    parameter int CLOCKS_PER_SAMPLE = AUDIO_CLOCKS_PER_SAMPLE,
    parameter int FIFO_DEPTH        = 2
) (
    input  logic                           clock,
    input  logic                           resetN,
    input  logic signed [SAMPLE_WIDTH-1:0] sampleLeft,
    input  logic signed [SAMPLE_WIDTH-1:0] sampleRight,
    input  logic                           sampleValid,
    output logic                           sampleReady,
    output logic                           sampleTick,
    output logic                           underrun,
    output logic                           dacLeft,
    output logic                           dacRight
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(CLOCKS_PER_SAMPLE);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] LAST_TICK  = CNT_W'(CLOCKS_PER_SAMPLE - 1);

    if (CLOCKS_PER_SAMPLE < 4 || FIFO_DEPTH != 2) begin : gBadParams
        $error("audio_pdm_dac: unsupported CLOCKS_PER_SAMPLE or FIFO_DEPTH");
    end

    logic [SAMPLE_WIDTH-1:0] fifoLeft  [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] fifoRight [FIFO_DEPTH];
    logic [PTR_W-1:0]        wrPtr, rdPtr;
    logic [PTR_W:0]          count;
    logic [CNT_W-1:0]        tickCount;
    logic [SAMPLE_WIDTH-1:0] curLeft, curRight;
    logic [1:0]              dither;
    logic                    full, empty, push, pop;

    // Ready deliberately ignores a same-cycle pop; a full buffer frees space next cycle.
    always_comb begin
        full        = (count == FULL_COUNT);
        empty       = (count == '0);
        sampleReady = !full;
        push        = sampleValid && !full;
        pop         = sampleTick && !empty;
        underrun    = sampleTick && empty;
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            tickCount  <= '0;
            sampleTick <= 1'b0;
        end else begin
            tickCount  <= (tickCount == LAST_TICK) ? '0 : tickCount + CNT_W'(1);
            sampleTick <= (tickCount == LAST_TICK);
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifoLeft[i]  <= '0;
                fifoRight[i] <= '0;
            end
            wrPtr    <= '0;
            rdPtr    <= '0;
            count    <= '0;
            curLeft  <= '0;
            curRight <= '0;
        end else begin
            if (push) begin
                fifoLeft[wrPtr]  <= sampleLeft;
                fifoRight[wrPtr] <= sampleRight;
                wrPtr            <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                curLeft  <= fifoLeft[rdPtr];
                curRight <= fifoRight[rdPtr];
                rdPtr    <= rdPtr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                count <= count - (PTR_W+1)'(1);
            end
        end
    end

`ifdef AUDIO_PDM_DITHER_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            lfsr <= AUDIO_LFSR_SEED;
        end else begin
            lfsr <= lfsrNext(lfsr);
        end
    end

    assign dither = lfsr[1:0];
`else
    assign dither = 2'b00;
`endif

    pdm_modulator_ch #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) uModLeft (
        .clock  (clock),
        .resetN (resetN),
        .sample (curLeft),
        .dither (dither),
        .dac    (dacLeft)
    );

    pdm_modulator_ch #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) uModRight (
        .clock  (clock),
        .resetN (resetN),
        .sample (curRight),
        .dither (dither),
        .dac    (dacRight)
    );

endmodule

// File: tb/tb_audio_pdm_dac.sv
// Bench for audio_pdm_dac: directed phases plus random frames, checked against a model
// where the ones emitted so far equal floor(total offset-binary input / 65536).
module tb_audio_pdm_dac;

    localparam int CPS = 256;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [15:0] sampleLeft = '0;
    logic [15:0] sampleRight = '0;
    logic        sampleValid = 1'b0;
    logic        sampleReady, sampleTick, underrun, dacLeft, dacRight;

    int errors = 0;
    int checks = 0;
    int dacMis = 0;
    int ctlMis = 0;

    audio_pdm_dac dut (
        .clock       (clock),
        .resetN      (resetN),
        .sampleLeft  (sampleLeft),
        .sampleRight (sampleRight),
        .sampleValid (sampleValid),
        .sampleReady (sampleReady),
        .sampleTick  (sampleTick),
        .underrun    (underrun),
        .dacLeft     (dacLeft),
        .dacRight    (dacRight)
    );

    always #5 clock = ~clock;

    // Reference model state
    int unsigned mEdges = 0;
    longint      mSumL = 0, mSumR = 0;
    bit          mCarryL = 0, mCarryR = 0, mDacL = 0, mDacR = 0, mTick = 0;
    int          mCurL = 0, mCurR = 0;
    int          qL[$];
    int          qR[$];
    logic [15:0] mLfsr = 16'hACE1;

    always @(posedge clock or negedge resetN) begin
        int     uL, uR, d;
        longint nL, nR;
        bit     doPop, doPush;
        if (!resetN) begin
            mEdges = 0; mSumL = 0; mSumR = 0;
            mCarryL = 0; mCarryR = 0; mDacL = 0; mDacR = 0; mTick = 0;
            mCurL = 0; mCurR = 0; mLfsr = 16'hACE1;
            qL.delete(); qR.delete();
        end else begin
            d = 0;
`ifdef AUDIO_PDM_DITHER_EN
            d = int'(mLfsr & 16'd3);
            mLfsr = mLfsr[0] ? ((mLfsr >> 1) ^ 16'hB400) : (mLfsr >> 1);
`endif
            uL = mCurL + 32768;
            uR = mCurR + 32768;
            nL = mSumL + longint'(uL) + longint'(d);
            nR = mSumR + longint'(uR) + longint'(d);
            mDacL = mCarryL;
            mDacR = mCarryR;
            mCarryL = ((nL >>> 16) != (mSumL >>> 16));
            mCarryR = ((nR >>> 16) != (mSumR >>> 16));
            mSumL = nL;
            mSumR = nR;
            doPop  = mTick && (qL.size() > 0);
            doPush = sampleValid && (qL.size() < 2);
            if (doPop) begin
                mCurL = qL.pop_front();
                mCurR = qR.pop_front();
            end
            if (doPush) begin
                qL.push_back(int'($signed(sampleLeft)));
                qR.push_back(int'($signed(sampleRight)));
            end
            mEdges++;
            mTick = (mEdges % CPS == 0);
        end
    end

    always @(negedge clock) begin
        if (dacLeft !== mDacL || dacRight !== mDacR) dacMis++;
        if (sampleReady !== (qL.size() < 2) || sampleTick !== mTick ||
            underrun !== (mTick && qL.size() == 0)) ctlMis++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic waitTick(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (sampleTick === 1'b1) begin
                ok = 1;
                break;
            end
        end
        check("tick_seen", 32'(ok), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with valid still high.
    task automatic pushFrame(input logic [15:0] l, input logic [15:0] r, input int budget);
        bit ok;
        ok = 0;
        sampleLeft  = l;
        sampleRight = r;
        sampleValid = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (sampleReady === 1'b1) begin
                @(negedge clock);
                ok = 1;
                break;
            end
            @(negedge clock);
        end
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    task automatic countOnes(input int n, output int l, output int r);
        l = 0;
        r = 0;
        repeat (n) begin
            @(negedge clock);
            l += int'(dacLeft);
            r += int'(dacRight);
        end
    endtask

    initial begin
        int  onesL, onesR;
        bit  found;
        logic [15:0] rl, rr;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ready", 32'(sampleReady), 32'd1);
        check("rst_tick", 32'(sampleTick), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_dacL", 32'(dacLeft), 32'd0);
        check("rst_dacR", 32'(dacRight), 32'd0);
        resetN = 1'b1;

        // Idle midscale, first tick underruns
        waitTick(300);
        check("first_tick_underrun", 32'(underrun), 32'd1);
        check("first_tick_edge", 32'(mEdges), 32'd256);
        countOnes(4096, onesL, onesR);
`ifndef AUDIO_PDM_DITHER_EN
        check("midscale_onesL", 32'(onesL), 32'd2048);
        check("midscale_onesR", 32'(onesR), 32'd2048);
`endif
        check("idle_dac_model", 32'(dacMis), 32'd0);

        // Full-scale frame: L max, R min
        pushFrame(16'h7FFF, 16'h8000, 10);
        sampleValid = 1'b0;
        waitTick(600);
        repeat (3) @(negedge clock);
        countOnes(4096, onesL, onesR);
`ifndef AUDIO_PDM_DITHER_EN
        check("fullscale_R_zero", 32'(onesR), 32'd0);
        check("fullscale_L_high", 32'(onesL >= 4095), 32'd1);
`endif
        check("fullscale_dac_model", 32'(dacMis), 32'd0);

        // Back-to-back pushes fill the buffer; third waits for a tick pop
        waitTick(300);
        @(negedge clock);
        pushFrame(16'h1111, 16'hEEEE, 10);
        pushFrame(16'h2222, 16'hDDDD, 10);
        check("ready_low_when_full", 32'(sampleReady), 32'd0);
        pushFrame(16'h3333, 16'hCCCC, 400);
        check("third_push_edge", mEdges % CPS, 32'd2);
        sampleValid = 1'b0;

        // Drain, then push and pop in the same cycle with one frame held
        waitTick(300);
        waitTick(300);
        waitTick(300);
        check("drain_underrun", 32'(underrun), 32'd1);
        pushFrame(16'h1234, 16'hF00D, 10);
        sampleValid = 1'b0;
        waitTick(300);
        check("simul_no_underrun", 32'(underrun), 32'd0);
        pushFrame(16'h7000, 16'h9000, 2);
        sampleValid = 1'b0;
        check("simul_ready", 32'(sampleReady), 32'd1);
        waitTick(300);
        check("simul_frame_kept", 32'(underrun), 32'd0);
        waitTick(300);
        check("simul_drained", 32'(underrun), 32'd1);
        check("ctl_model_mid", 32'(ctlMis), 32'd0);

        // Reset mid-stream with two frames buffered
        pushFrame(16'h6000, 16'hA000, 10);
        pushFrame(16'h5000, 16'hB000, 10);
        sampleValid = 1'b0;
        check("pre_reset_full", 32'(sampleReady), 32'd0);
        found = 0;
        for (int i = 0; i < 64; i++) begin
            if (dacLeft === 1'b1) begin
                found = 1;
                break;
            end
            @(negedge clock);
        end
        check("pre_reset_dac_high", 32'(found), 32'd1);
        #2 resetN = 1'b0;
        #1;
        check("async_rst_dacL", 32'(dacLeft), 32'd0);
        check("async_rst_dacR", 32'(dacRight), 32'd0);
        check("async_rst_ready", 32'(sampleReady), 32'd1);
        repeat (2) @(negedge clock);
        resetN = 1'b1;
        check("post_reset_ready", 32'(sampleReady), 32'd1);
        waitTick(300);
        check("post_reset_underrun", 32'(underrun), 32'd1);
        check("post_reset_tick_edge", 32'(mEdges), 32'd256);
        countOnes(512, onesL, onesR);
`ifndef AUDIO_PDM_DITHER_EN
        check("post_reset_midscale", 32'(onesL), 32'd256);
`endif

        // Random frames with random gaps
        for (int n = 0; n < 24; n++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            if (n % 6 == 0) begin
                rl = 16'h7FFF;
                rr = 16'h8000;
            end
            pushFrame(rl, rr, 600);
            sampleValid = 1'b0;
            repeat ($urandom_range(0, 300)) @(negedge clock);
        end
        repeat (700) @(negedge clock);
        check("random_dac_model", 32'(dacMis), 32'd0);
        check("random_ctl_model", 32'(ctlMis), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
